lc3_control: RTL

- Multicycle control FSM for the LC3 datapath.
- Consumes IR and the N/Z/P flags from the datapath and drives every datapath control input, one register transfer per cycle.
- Sequences fetch/decode/execute; memory read/write dwell is stretched by a parameter.

---
 rtl/lc3_ctrl_pkg.sv | 69 ++++++
 rtl/lc3_control_outputs.sv | 110 +++++++++++
 rtl/lc3_control.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC3 multicycle controller.
// The control vector struct carries every datapath control from the decoder to the top.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCH2, DECODE, EXEC, J1, J2, M1, M2, M3, S2, S3, HALT
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_RSVA = 4'b1010;
  localparam logic [3:0] OP_RSVB = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSVD = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_EAB = 2'b01;
  localparam logic [1:0] PC_BUS = 2'b10;

  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  typedef struct packed {
    logic [1:0] alu;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic [1:0] sel_pc;
    logic       sel_eab1;
    logic [1:0] sel_eab2;
    logic       sel_mar;
    logic       sel_mdr;
    logic       ena_alu;
    logic       ena_marm;
    logic       ena_pc;
    logic       ena_mdr;
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_mar;
    logic       ld_mdr;
    logic       reg_we;
    logic       flag_we;
    logic       mem_we;
    logic       halted;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_RTI) || (op == OP_RSVA) || (op == OP_RSVB) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/lc3_control_outputs.sv
// Combinational decode of controller state, IR and flags into the datapath control vector.
module lc3_ctrl_outputs
  import lc3_ctrl_pkg::*;
(
  input  state_t      state_i,
  input  logic [15:0] ir_i,
  input  logic        n_i,
  input  logic        z_i,
  input  logic        p_i,
  input  logic        wait_done_i,
  output ctrl_t       ctrl_o
);

  logic [3:0] op;
  logic       br_taken;
  logic       unused_ir;

  assign op        = ir_i[15:12];
  assign br_taken  = (ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i);
  assign unused_ir = ^ir_i[5:3];

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.sr1 = ir_i[8:6];
    ctrl_o.sr2 = ir_i[2:0];
    ctrl_o.dr  = ir_i[11:9];
    case (state_i)
      FETCH0: begin
        ctrl_o.ena_pc = 1'b1;
        ctrl_o.ld_mar = 1'b1;
        ctrl_o.ld_pc  = 1'b1;
        ctrl_o.sel_pc = PC_INC;
      end
      // Memory read dwell: data is only captured on the final cycle.
      FETCH1, M2: ctrl_o.ld_mdr = wait_done_i;
      FETCH2: begin
        ctrl_o.ena_mdr = 1'b1;
        ctrl_o.ld_ir   = 1'b1;
      end
      DECODE: ctrl_o.illegal_op = is_illegal(op);
      EXEC: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            ctrl_o.alu     = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_NOT;
            ctrl_o.ena_alu = 1'b1;
            ctrl_o.reg_we  = 1'b1;
            ctrl_o.flag_we = 1'b1;
          end
          OP_BR: begin
            if (br_taken) begin
              ctrl_o.ld_pc    = 1'b1;
              ctrl_o.sel_pc   = PC_EAB;
              ctrl_o.sel_eab2 = EAB2_OFF9;
            end
          end
          OP_JMP: begin
            ctrl_o.ld_pc    = 1'b1;
            ctrl_o.sel_pc   = PC_EAB;
            ctrl_o.sel_eab1 = 1'b1;
            ctrl_o.sel_eab2 = EAB2_ZERO;
          end
          OP_LEA: begin
            ctrl_o.ena_marm = 1'b1;
            ctrl_o.sel_eab2 = EAB2_OFF9;
            ctrl_o.reg_we   = 1'b1;
          end
          default: ;
        endcase
      end
      J1: begin
        ctrl_o.ena_pc = 1'b1;
        ctrl_o.reg_we = 1'b1;
        ctrl_o.dr     = 3'd7;
      end
      J2: begin
        ctrl_o.ld_pc  = 1'b1;
        ctrl_o.sel_pc = PC_EAB;
        if (ir_i[11]) ctrl_o.sel_eab2 = EAB2_OFF11;
        else          ctrl_o.sel_eab1 = 1'b1;
      end
      // IR[14] separates the base+offset6 forms (LDR/STR) from PC+offset9 (LD/ST).
      M1: begin
        ctrl_o.ena_marm = 1'b1;
        ctrl_o.ld_mar   = 1'b1;
        if (ir_i[14]) begin
          ctrl_o.sel_eab1 = 1'b1;
          ctrl_o.sel_eab2 = EAB2_OFF6;
        end else begin
          ctrl_o.sel_eab2 = EAB2_OFF9;
        end
      end
      M3: begin
        ctrl_o.ena_mdr = 1'b1;
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.flag_we = 1'b1;
      end
      S2: begin
        ctrl_o.ena_alu = 1'b1;
        ctrl_o.alu     = ALU_PASS;
        ctrl_o.sr1     = ir_i[11:9];
        ctrl_o.ld_mdr  = 1'b1;
        ctrl_o.sel_mdr = 1'b1;
      end
      S3:      ctrl_o.mem_we = 1'b1;
      HALT:    ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_control.sv
// LC3 multicycle control FSM: fetch/decode/execute sequencing with a memory dwell counter.
// Control outputs are decoded combinationally; reset forces every enable/load/write low.
module lc3_control
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMAR,
  output logic        selMDR,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic        memWE,
  output logic        halted,
  output logic        illegal_op
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       wait_done;
  logic [3:0] op;
  ctrl_t      ctrl;
  logic       run;

  assign op        = IR[15:12];
  assign wait_done = (wait_q == 4'd0);
  assign run       = ~reset;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      FETCH0: begin
        state_d = FETCH1;
        wait_d  = WAIT_INIT;
      end
      FETCH1: begin
        if (wait_done) state_d = FETCH2;
        else           wait_d  = wait_q - 4'd1;
      end
      FETCH2: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_BR, OP_ADD, OP_AND, OP_NOT, OP_JMP, OP_LEA: state_d = EXEC;
          OP_JSR:                                        state_d = J1;
          OP_LD, OP_LDR, OP_ST, OP_STR:                  state_d = M1;
          OP_TRAP:                                       state_d = HALT;
          default:                                       state_d = FETCH0;
        endcase
      end
      EXEC: state_d = FETCH0;
      J1:   state_d = J2;
      J2:   state_d = FETCH0;
      // IR[12] is clear for the loads and set for the stores.
      M1: begin
        if (!IR[12]) begin
          state_d = M2;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S2;
        end
      end
      M2: begin
        if (wait_done) state_d = M3;
        else           wait_d  = wait_q - 4'd1;
      end
      M3: state_d = FETCH0;
      S2: begin
        state_d = S3;
        wait_d  = WAIT_INIT;
      end
      S3: begin
        if (wait_done) state_d = FETCH0;
        else           wait_d  = wait_q - 4'd1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH0;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  lc3_ctrl_outputs u_outputs (
    .state_i     (state_q),
    .ir_i        (IR),
    .n_i         (N),
    .z_i         (Z),
    .p_i         (P),
    .wait_done_i (wait_done),
    .ctrl_o      (ctrl)
  );

  assign aluControl = ctrl.alu;
  assign SR1        = ctrl.sr1;
  assign SR2        = ctrl.sr2;
  assign DR         = ctrl.dr;
  assign selPC      = ctrl.sel_pc;
  assign selEAB1    = ctrl.sel_eab1;
  assign selEAB2    = ctrl.sel_eab2;
  assign selMAR     = ctrl.sel_mar;
  assign selMDR     = ctrl.sel_mdr;
  assign enaALU     = ctrl.ena_alu & run;
  assign enaMARM    = ctrl.ena_marm & run;
  assign enaPC      = ctrl.ena_pc & run;
  assign enaMDR     = ctrl.ena_mdr & run;
  assign ldPC       = ctrl.ld_pc & run;
  assign ldIR       = ctrl.ld_ir & run;
  assign ldMAR      = ctrl.ld_mar & run;
  assign ldMDR      = ctrl.ld_mdr & run;
  assign regWE      = ctrl.reg_we & run;
  assign flagWE     = ctrl.flag_we & run;
  assign memWE      = ctrl.mem_we & run;
  assign halted     = ctrl.halted;
  assign illegal_op = ctrl.illegal_op & run;

endmodule
